// File: rtl/pipe_nodatahazards_mem.sv
// rtl/pipe_nodatahazards_mem.sv - MIPS MEM stage: EX/MEM register plus word-addressed data memory

// Word-addressed data memory: asynchronous read, synchronous write
module data_mem #(
    parameter int ADDR_BITS = 5
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [31:0]          din,
    output logic [31:0]          dout
);
    localparam int DEPTH = 2 ** ADDR_BITS;

    logic [31:0] r_mem [DEPTH];

    // Store lands at the clock edge; contents are never cleared by reset
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= din;
        end
    end

    // Read path is combinational so a load sees data in its own MEM cycle
    always_comb begin
        dout = r_mem[addr];
    end
endmodule

// EX/MEM pipeline register, cleared on synchronous active-low reset
module pipe_EX_MEM_reg (
    input  logic        clk,
    input  logic        clrn,
    input  logic        EXwreg,
    input  logic        EXm2reg,
    input  logic        EXwmem,
    input  logic [4:0]  EXwn,
    input  logic [31:0] EXaluResult,
    input  logic [31:0] EXqb,
    output logic        MEMwreg,
    output logic        MEMm2reg,
    output logic        MEMwmem,
    output logic [4:0]  MEMwn,
    output logic [31:0] MEMaluResult,
    output logic [31:0] MEMqb
);
    logic        r_wreg;
    logic        r_m2reg;
    logic        r_wmem;
    logic [4:0]  r_wn;
    logic [31:0] r_alu_result;
    logic [31:0] r_qb;

    // Advance one instruction every cycle; reset zeroes every field
    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_wreg       <= 1'b0;
            r_m2reg      <= 1'b0;
            r_wmem       <= 1'b0;
            r_wn         <= 5'd0;
            r_alu_result <= 32'd0;
            r_qb         <= 32'd0;
        end else begin
            r_wreg       <= EXwreg;
            r_m2reg      <= EXm2reg;
            r_wmem       <= EXwmem;
            r_wn         <= EXwn;
            r_alu_result <= EXaluResult;
            r_qb         <= EXqb;
        end
    end

    assign MEMwreg      = r_wreg;
    assign MEMm2reg     = r_m2reg;
    assign MEMwmem      = r_wmem;
    assign MEMwn        = r_wn;
    assign MEMaluResult = r_alu_result;
    assign MEMqb        = r_qb;
endmodule

// MEM stage top: registered EX controls drive the data memory
module pipe_nodatahazards_mem #(
    parameter int ADDR_BITS = 5
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        EXwreg,
    input  logic        EXm2reg,
    input  logic        EXwmem,
    input  logic [4:0]  EXwn,
    input  logic [31:0] EXaluResult,
    input  logic [31:0] EXqb,
    output logic        MEMwreg,
    output logic        MEMm2reg,
    output logic [4:0]  MEMwn,
    output logic [31:0] MEMaluResult,
    output logic [31:0] MEMmemOut
);
    logic                 w_wmem;
    logic [31:0]          w_qb;
    logic                 w_we;
    logic [ADDR_BITS-1:0] w_index;

    pipe_EX_MEM_reg u_ex_mem (
        .clk          (clk),
        .clrn         (clrn),
        .EXwreg       (EXwreg),
        .EXm2reg      (EXm2reg),
        .EXwmem       (EXwmem),
        .EXwn         (EXwn),
        .EXaluResult  (EXaluResult),
        .EXqb         (EXqb),
        .MEMwreg      (MEMwreg),
        .MEMm2reg     (MEMm2reg),
        .MEMwmem      (w_wmem),
        .MEMwn        (MEMwn),
        .MEMaluResult (MEMaluResult),
        .MEMqb        (w_qb)
    );

    // Byte offset and high address bits are dropped: unaligned accesses hit
    // the containing word and addresses alias modulo the memory size.
    assign w_index = MEMaluResult[ADDR_BITS+1:2];

    // A reset arriving on the store's write edge cancels the store
    assign w_we = w_wmem & clrn;

    data_mem #(.ADDR_BITS(ADDR_BITS)) u_dmem (
        .clk  (clk),
        .we   (w_we),
        .addr (w_index),
        .din  (w_qb),
        .dout (MEMmemOut)
    );
endmodule

// File: tb/tb_pipe_nodatahazards_mem.sv
// tb/tb_pipe_nodatahazards_mem.sv - self-checking bench for pipe_nodatahazards_mem

module tb_pipe_nodatahazards_mem;
    localparam int ADDR_BITS = 5;
    localparam int DEPTH     = 2 ** ADDR_BITS;

    logic        clk;
    logic        clrn;
    logic        EXwreg;
    logic        EXm2reg;
    logic        EXwmem;
    logic [4:0]  EXwn;
    logic [31:0] EXaluResult;
    logic [31:0] EXqb;
    logic        MEMwreg;
    logic        MEMm2reg;
    logic [4:0]  MEMwn;
    logic [31:0] MEMaluResult;
    logic [31:0] MEMmemOut;

    int n_pass;
    int n_total;
    bit chk_en;

    // Reference model state: what the stage is currently presenting
    logic        m_wreg;
    logic        m_m2reg;
    logic        m_wmem;
    logic [4:0]  m_wn;
    logic [31:0] m_alu;
    logic [31:0] m_qb;
    logic [31:0] m_mem [DEPTH];

    pipe_nodatahazards_mem #(.ADDR_BITS(ADDR_BITS)) dut (
        .clk          (clk),
        .clrn         (clrn),
        .EXwreg       (EXwreg),
        .EXm2reg      (EXm2reg),
        .EXwmem       (EXwmem),
        .EXwn         (EXwn),
        .EXaluResult  (EXaluResult),
        .EXqb         (EXqb),
        .MEMwreg      (MEMwreg),
        .MEMm2reg     (MEMm2reg),
        .MEMwn        (MEMwn),
        .MEMaluResult (MEMaluResult),
        .MEMmemOut    (MEMmemOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    endtask

    function automatic int word_of(input logic [31:0] byte_addr);
        return int'((byte_addr / 4) % DEPTH);
    endfunction

    // Model: at each edge, a pending store commits (unless reset), then the
    // instruction on the EX inputs becomes the one in MEM.
    always @(posedge clk) begin
        if (!clrn) begin
            m_wreg = 0; m_m2reg = 0; m_wmem = 0; m_wn = 0; m_alu = 0; m_qb = 0;
        end else begin
            if (m_wmem === 1'b1) m_mem[word_of(m_alu)] = m_qb;
            m_wreg = EXwreg; m_m2reg = EXm2reg; m_wmem = EXwmem;
            m_wn = EXwn; m_alu = EXaluResult; m_qb = EXqb;
        end
    end

    // Compare DUT against the model mid-cycle, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_wreg",   {31'd0, MEMwreg},  {31'd0, m_wreg});
            chk("cyc_m2reg",  {31'd0, MEMm2reg}, {31'd0, m_m2reg});
            chk("cyc_wn",     {27'd0, MEMwn},    {27'd0, m_wn});
            chk("cyc_alu",    MEMaluResult,      m_alu);
            chk("cyc_memout", MEMmemOut,         m_mem[word_of(m_alu)]);
        end
    end

    task automatic cyc(input logic rst_n, input logic wreg, input logic m2reg, input logic wmem,
                       input logic [4:0] wn, input logic [31:0] alu, input logic [31:0] qb);
        clrn = rst_n; EXwreg = wreg; EXm2reg = m2reg; EXwmem = wmem;
        EXwn = wn; EXaluResult = alu; EXqb = qb;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_pass = 0; n_total = 0; chk_en = 0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'd0;
        clrn = 0; EXwreg = 0; EXm2reg = 0; EXwmem = 0; EXwn = 0; EXaluResult = 0; EXqb = 0;
        cyc(0, 0, 0, 0, 0, 0, 0);
        // Bring memory to a known all-zero state before full-cycle checking
        for (int i = 0; i < DEPTH; i++) cyc(1, 0, 0, 1, 0, 32'(i * 4), 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk_en = 1;

        // Reset holds outputs at zero and blocks the store presented during it
        cyc(0, 1, 0, 1, 5'd9, 32'h10, 32'hFFFF_FFFF);
        cyc(0, 1, 0, 1, 5'd9, 32'h10, 32'hFFFF_FFFF);
        chk("rst_wreg",  {31'd0, MEMwreg},  32'd0);
        chk("rst_m2reg", {31'd0, MEMm2reg}, 32'd0);
        chk("rst_wn",    {27'd0, MEMwn},    32'd0);
        chk("rst_alu",   MEMaluResult,      32'd0);
        cyc(1, 0, 1, 0, 0, 32'h10, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 0, 0, 32'h10, 0);
        chk("rst_mem4", MEMmemOut, 32'd0);

        // Store then load of the same word in the next cycle
        cyc(1, 0, 0, 1, 0, 32'h8, 32'hDEAD_BEEF);
        cyc(1, 1, 1, 0, 5'd3, 32'h8, 0);
        chk("s2l_data",  MEMmemOut,         32'hDEAD_BEEF);
        chk("s2l_m2reg", {31'd0, MEMm2reg}, 32'd1);
        chk("s2l_wn",    {27'd0, MEMwn},    32'd3);

        // Aliased high address and unaligned low bits reach the same word
        cyc(1, 0, 0, 1, 0, 32'h84, 32'h1234_5678);
        cyc(1, 1, 1, 0, 5'd1, 32'h7, 0);
        chk("alias", MEMmemOut, 32'h1234_5678);

        // Read during write shows old data, new data from the next edge
        cyc(1, 0, 0, 1, 0, 32'hC, 32'hAAAA_AAAA);
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 0, 32'hC, 32'h5555_5555);
        chk("rdw_old", MEMmemOut, 32'hAAAA_AAAA);
        cyc(1, 1, 1, 0, 5'd2, 32'hC, 0);
        chk("rdw_new", MEMmemOut, 32'h5555_5555);

        // Reset on the write edge of a pending store cancels it
        cyc(1, 0, 0, 1, 0, 32'h10, 32'hCAFE_F00D);
        cyc(0, 0, 0, 0, 0, 32'h10, 0);
        chk("rstw_alu", MEMaluResult, 32'd0);
        cyc(1, 1, 1, 0, 5'd4, 32'h10, 0);
        chk("rstw_mem4", MEMmemOut, 32'd0);

        // Pass-through stream of non-memory ops, one cycle latency each
        for (int i = 0; i < 8; i++) begin
            cyc(1, 1, 0, 0, 5'(i), 32'(i) * 32'h1111, 32'hFFFF_0000 | 32'(i));
            chk("pass_alu", MEMaluResult, 32'(i) * 32'h1111);
            chk("pass_wn",  {27'd0, MEMwn}, 32'(i));
        end
        for (int i = 0; i < DEPTH; i++) cyc(1, 1, 1, 0, 5'd1, 32'(i * 4), 0);

        // Randomized traffic with narrow address reuse and occasional reset
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 15));
            cyc(($urandom_range(0, 31) != 0), 1'($urandom), 1'($urandom),
                1'($urandom), 5'($urandom), a, $urandom);
        end
        for (int i = 0; i < DEPTH; i++) cyc(1, 0, 1, 0, 0, 32'(i * 4), 0);

        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
